// File: rtl/tof_range_poller_if.sv
// tof_range_poller_if: command/response bundle between the poller and the I2C master engine
interface tof_range_poller_if;
  logic        i2c_start;
  logic [6:0]  i2c_slave_address;
  logic [15:0] i2c_register_address;
  logic [7:0]  i2c_data_in;
  logic        i2c_is_read;
  logic [9:0]  i2c_nb_of_bytes;
  logic        i2c_ready;
  logic [15:0] i2c_data_out;
  logic        i2c_error;
  modport master (
    output i2c_start, i2c_slave_address, i2c_register_address, i2c_data_in, i2c_is_read, i2c_nb_of_bytes,
    input  i2c_ready, i2c_data_out, i2c_error
  );
  modport slave (
    input  i2c_start, i2c_slave_address, i2c_register_address, i2c_data_in, i2c_is_read, i2c_nb_of_bytes,
    output i2c_ready, i2c_data_out, i2c_error
  );
endinterface

// File: rtl/tof_range_poller.sv
// tof_range_poller: starts ToF ranging, polls data-ready status, reads the 16-bit distance
module tof_range_poller #(
  parameter logic [6:0]  SLAVE_ADDR       = 7'h29,
  parameter logic [15:0] START_REG        = 16'h0087,
  parameter logic [7:0]  START_VAL        = 8'h40,
  parameter logic [15:0] STATUS_REG       = 16'h0031,
  parameter int          STATUS_BIT       = 0,
  parameter logic        STATUS_READY_VAL = 1'b0,
  parameter logic [15:0] DIST_REG         = 16'h0096,
  parameter logic [15:0] POLL_INTERVAL    = 16'd5000,
  parameter logic [7:0]  MAX_POLLS        = 8'd100,
  parameter logic [19:0] TXN_TIMEOUT      = 20'd200000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                continuous,
  tof_range_poller_if.master  bus,
  output logic [15:0]         distance,
  output logic                distance_valid,
  output logic                busy,
  output logic                error,
  output logic [1:0]          error_code
);
  localparam logic [2:0] IDLE = 3'd0, WR_START = 3'd1, POLL_WAIT = 3'd2, RD_STATUS = 3'd3,
                         RD_DIST = 3'd4, RESULT = 3'd5, ERR = 3'd6;
  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  polls_q, polls_d;
  logic        cont_q, cont_d, start_q, start_d, rd_q, rd_d;
  logic [15:0] reg_q, reg_d, dist_q, dist_d;
  logic [7:0]  din_q, din_d;
  logic [9:0]  nb_q, nb_d;
  logic [1:0]  code_q, code_d;
  logic        txn, done, status_ready;
  assign txn = state_q inside {WR_START, RD_STATUS, RD_DIST};
  assign done = cnt_q >= 20'd2 && bus.i2c_ready;
  assign status_ready = bus.i2c_data_out[STATUS_BIT] == STATUS_READY_VAL;
  // Next-state logic; cnt times both the poll interval and the in-flight transaction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 20'd1;
    polls_d = polls_q;
    cont_d  = cont_q;
    start_d = 1'b0;
    reg_d   = reg_q;
    din_d   = din_q;
    rd_d    = rd_q;
    nb_d    = nb_q;
    dist_d  = dist_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d = WR_START;
        cont_d  = continuous;
      end
      WR_START: if (done) begin
        state_d = POLL_WAIT;
        polls_d = '0;
      end
      POLL_WAIT: if (cnt_q == {4'd0, POLL_INTERVAL - 16'd1}) state_d = RD_STATUS;
      RD_STATUS: if (done) begin
        if (status_ready) state_d = RD_DIST;
        else if (polls_q + 8'd1 == MAX_POLLS) begin
          state_d = ERR;
          code_d  = 2'd3;
        end else begin
          state_d = POLL_WAIT;
          polls_d = polls_q + 8'd1;
        end
      end
      RD_DIST: if (done) begin
        state_d = RESULT;
        dist_d  = bus.i2c_data_out;
      end
      RESULT: begin
        state_d = cont_q && enable ? POLL_WAIT : IDLE;
        polls_d = '0;
      end
      ERR: if (!enable) begin
        state_d = IDLE;
        code_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    if (txn && bus.i2c_error) begin
      state_d = ERR;
      code_d  = 2'd2;
      dist_d  = dist_q;
    end else if (txn && !done && cnt_q == TXN_TIMEOUT - 20'd1) begin
      state_d = ERR;
      code_d  = 2'd1;
    end
    if (state_d != state_q) cnt_d = '0;
    if (state_d != state_q && state_d inside {WR_START, RD_STATUS, RD_DIST}) begin
      start_d = 1'b1;
      reg_d   = state_d == WR_START ? START_REG : state_d == RD_STATUS ? STATUS_REG : DIST_REG;
      din_d   = state_d == WR_START ? START_VAL : 8'h00;
      rd_d    = state_d != WR_START;
      nb_d    = state_d == RD_DIST ? 10'd2 : 10'd1;
    end
  end
  // State and registered command outputs; reset abandons any in-flight transaction
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      polls_q <= '0;
      cont_q  <= 1'b0;
      start_q <= 1'b0;
      reg_q   <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      nb_q    <= '0;
      dist_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      polls_q <= polls_d;
      cont_q  <= cont_d;
      start_q <= start_d;
      reg_q   <= reg_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      nb_q    <= nb_d;
      dist_q  <= dist_d;
      code_q  <= code_d;
    end
  end
  assign bus.i2c_start            = start_q;
  assign bus.i2c_slave_address    = SLAVE_ADDR;
  assign bus.i2c_register_address = reg_q;
  assign bus.i2c_data_in          = din_q;
  assign bus.i2c_is_read          = rd_q;
  assign bus.i2c_nb_of_bytes      = nb_q;
  assign distance       = dist_q;
  assign distance_valid = state_q == RESULT;
  assign busy           = !(state_q inside {IDLE, ERR});
  assign error          = state_q == ERR;
  assign error_code     = code_q;
endmodule

// File: tb/tb_tof_range_poller.sv
// tb_tof_range_poller: engine model plus scoreboard for distance strobes and error events
module tb_tof_range_poller;
  localparam logic [15:0] PI = 16'd20;
  localparam logic [7:0]  MP = 8'd5;
  localparam logic [19:0] TO = 20'd300;
  logic clock = 0, reset = 0, enable = 0, continuous = 0;
  logic [15:0] distance;
  logic distance_valid, busy, error;
  logic [1:0] error_code;
  tof_range_poller_if bus();
  tof_range_poller #(.POLL_INTERVAL(PI), .MAX_POLLS(MP), .TXN_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .continuous(continuous), .bus(bus),
    .distance(distance), .distance_valid(distance_valid), .busy(busy), .error(error),
    .error_code(error_code)
  );
  always #5 clock = ~clock;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_start = 0, n_wr = 0, n_st = 0, n_dr = 0, n_valid = 0;
  int t_start = 0, t_last_st = 0, min_gap = 1000000, lat = 0, kind_cur = 0, first_kind = 0;
  bit hang = 0, errinj = 0, arm_first = 0, prev_valid = 0, prev_err = 0;
  logic [15:0] stat_src[$], dist_src[$], exp_q[$];
  int err_q[$];
  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clock);
    cyc++;
  end
  // Engine model: classifies each start pulse and answers with ready three cycles later
  initial begin
    bus.i2c_ready = 0;
    bus.i2c_data_out = 0;
    bus.i2c_error = 0;
    forever begin
      @(negedge clock);
      bus.i2c_ready = 0;
      bus.i2c_error = 0;
      if (!reset) begin
        lat = 0;
        stat_src.delete();
        dist_src.delete();
      end else if (bus.i2c_start) begin
        n_start++;
        kind_cur = (!bus.i2c_is_read && bus.i2c_register_address == 16'h0087 && bus.i2c_data_in == 8'h40 && bus.i2c_nb_of_bytes == 10'd1) ? 1 :
                   (bus.i2c_is_read && bus.i2c_register_address == 16'h0031 && bus.i2c_nb_of_bytes == 10'd1) ? 2 :
                   (bus.i2c_is_read && bus.i2c_register_address == 16'h0096 && bus.i2c_nb_of_bytes == 10'd2) ? 3 : 0;
        if (arm_first) begin
          first_kind = kind_cur;
          arm_first = 0;
        end
        if (kind_cur == 1) begin
          n_wr++;
          t_start = cyc;
        end
        if (kind_cur == 2) begin
          if (n_st > 0 && cyc - t_last_st < min_gap) min_gap = cyc - t_last_st;
          t_last_st = cyc;
          n_st++;
        end
        if (kind_cur == 3) n_dr++;
        lat = hang ? 0 : 3;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus.i2c_ready = 1;
          bus.i2c_error = errinj;
          bus.i2c_data_out = 16'h0000;
          if (kind_cur == 2) bus.i2c_data_out = stat_src.size() > 0 ? stat_src.pop_front() : 16'h0001;
          if (kind_cur == 3) bus.i2c_data_out = dist_src.size() > 0 ? dist_src.pop_front() : 16'hDEAD;
        end
      end
    end
  end
  // Monitor: pops expected distances on each strobe and expected codes on each error rise
  initial forever begin
    @(negedge clock);
    if (distance_valid) begin
      n_valid++;
      check("valid_single_cycle", prev_valid, 0);
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("distance", distance, exp_q.pop_front());
    end
    if (error && !prev_err) begin
      if (err_q.size() == 0) check("unexpected_error", 1, 0);
      else check("error_code", error_code, err_q.pop_front());
    end
    prev_valid = distance_valid;
    prev_err = error;
  end
  task automatic wait_valids(int target);
    for (int i = 0; i < 20000 && n_valid < target; i++) @(negedge clock);
    check("wait_valid_bound", n_valid >= target, 1);
  endtask
  task automatic wait_err();
    for (int i = 0; i < 20000 && !error; i++) @(negedge clock);
    check("wait_error_bound", error, 1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20000 && busy; i++) @(negedge clock);
    check("wait_idle_bound", busy, 0);
  endtask
  task automatic pulse_enable();
    enable = 1;
    @(negedge clock);
    enable = 0;
  endtask
  task automatic check_reset_outputs();
    check("rst_start", bus.i2c_start, 0);
    check("rst_regaddr", bus.i2c_register_address, 0);
    check("rst_data_in", bus.i2c_data_in, 0);
    check("rst_is_read", bus.i2c_is_read, 0);
    check("rst_nb", bus.i2c_nb_of_bytes, 0);
    check("rst_slave", bus.i2c_slave_address, 7'h29);
    check("rst_distance", distance, 0);
    check("rst_valid", distance_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_code", error_code, 0);
  endtask
  initial begin
    int b_wr, b_st, b_dr, b_start, b_valid;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1;
    @(negedge clock);
    stat_src.push_back(16'h0000);
    dist_src.push_back(16'h01F4);
    exp_q.push_back(16'h01F4);
    pulse_enable();
    wait_valids(1);
    wait_idle();
    check("t1_writes", n_wr, 1);
    check("t1_status_reads", n_st, 1);
    check("t1_dist_reads", n_dr, 1);
    check("t1_distance_hold", distance, 16'h01F4);
    b_st = n_st;
    b_dr = n_dr;
    min_gap = 1000000;
    for (int i = 0; i < 3; i++) stat_src.push_back(16'h0001);
    stat_src.push_back(16'h0000);
    dist_src.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    pulse_enable();
    wait_valids(2);
    wait_idle();
    check("t2_status_reads", n_st - b_st, 4);
    check("t2_dist_reads", n_dr - b_dr, 1);
    check("t2_poll_spacing_ok", min_gap >= int'(PI), 1);
    check("t2_error", error, 0);
    b_st = n_st;
    err_q.push_back(3);
    enable = 1;
    wait_err();
    check("t3_status_reads", n_st - b_st, int'(MP));
    check("t3_busy", busy, 0);
    repeat (5) @(negedge clock);
    check("t3_sticky", error, 1);
    check("t3_dist_kept", distance, 16'h1234);
    enable = 0;
    @(negedge clock);
    check("t3_cleared", error, 0);
    check("t3_code_cleared", error_code, 0);
    hang = 1;
    b_start = n_start;
    err_q.push_back(1);
    enable = 1;
    wait_err();
    check("t4_timeout_cycles", cyc - t_start, int'(TO));
    repeat (20) @(negedge clock);
    check("t4_no_restart", n_start - b_start, 1);
    check("t4_start_low", bus.i2c_start, 0);
    enable = 0;
    @(negedge clock);
    check("t4_cleared", error, 0);
    hang = 0;
    errinj = 1;
    err_q.push_back(2);
    enable = 1;
    wait_err();
    enable = 0;
    @(negedge clock);
    errinj = 0;
    check("t5_cleared", error, 0);
    b_wr = n_wr;
    b_dr = n_dr;
    b_valid = n_valid;
    for (int i = 1; i <= 3; i++) begin
      stat_src.push_back(16'h0000);
      dist_src.push_back(16'(i * 256));
      exp_q.push_back(16'(i * 256));
    end
    continuous = 1;
    enable = 1;
    wait_valids(b_valid + 2);
    repeat (3) @(negedge clock);
    enable = 0;
    wait_valids(b_valid + 3);
    wait_idle();
    repeat (40) @(negedge clock);
    check("t6_start_writes", n_wr - b_wr, 1);
    check("t6_dist_reads", n_dr - b_dr, 3);
    check("t6_strobes", n_valid - b_valid, 3);
    check("t6_idle", busy, 0);
    continuous = 0;
    b_dr = n_dr;
    stat_src.push_back(16'h0000);
    dist_src.push_back(16'h7777);
    enable = 1;
    for (int i = 0; i < 20000 && n_dr == b_dr; i++) @(negedge clock);
    check("t7_reached_rd_dist", n_dr - b_dr, 1);
    reset = 0;
    enable = 0;
    @(negedge clock);
    check_reset_outputs();
    @(negedge clock);
    reset = 1;
    arm_first = 1;
    @(negedge clock);
    stat_src.push_back(16'h0000);
    dist_src.push_back(16'h0ABC);
    exp_q.push_back(16'h0ABC);
    pulse_enable();
    wait_valids(n_valid + 1);
    wait_idle();
    check("t7_first_txn_write", first_kind, 1);
    check("t7_distance", distance, 16'h0ABC);
    check("exp_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
